// File: rtl/tx_am_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tx_am_scheduler_pkg
//  Description : Shared block-type codes, widths and defaults for the TX slot
//                scheduler and its encoder-side consumers.
//  Revision    : 1.0  initial release
// ============================================================================
package tx_am_scheduler_pkg;

    localparam int c_nb_data_coded_def = 66;
    localparam int c_n_lanes_def       = 20;
    localparam int c_am_period_def     = 327680;
    localparam int c_max_deficit_def   = 63;

    localparam int c_type_w    = 4;
    localparam int c_lane_w    = 5;
    localparam int c_deficit_w = 6;

    typedef enum logic [c_type_w-1:0] {
        TYPE_E = 4'b0000,
        TYPE_T = 4'b0001,
        TYPE_C = 4'b0010,
        TYPE_S = 4'b0100,
        TYPE_D = 4'b1000
    } tx_type_e;

    // Frame tracking: start opens a frame, terminate or idle closes it.
    function automatic logic next_in_frame(input logic cur, input logic [c_type_w-1:0] blk_type);
        case (blk_type)
            TYPE_S:         return 1'b1;
            TYPE_T, TYPE_C: return 1'b0;
            default:        return cur;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_am_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : tx_am_scheduler_if
//  Description : Upstream block channel and encoder-side outputs of the TX
//                slot scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
interface tx_am_scheduler_if
    import tx_am_scheduler_pkg::*;
#(
    parameter int NB_DATA_CODED = c_nb_data_coded_def
);
    logic                      i_enable;
    logic                      i_valid;
    logic [c_type_w-1:0]       i_tx_type;
    logic [NB_DATA_CODED-1:0]  i_tx_coded;
    logic                      o_ready;
    logic                      o_enc_valid;
    logic [c_type_w-1:0]       o_tx_type;
    logic [NB_DATA_CODED-1:0]  o_tx_coded;
    logic                      o_am_insert;
    logic [c_lane_w-1:0]       o_am_lane;
    logic [c_deficit_w-1:0]    o_deficit;
    logic                      o_deficit_ovf;

    // Scheduler side
    modport slave (
        input  i_enable, i_valid, i_tx_type, i_tx_coded,
        output o_ready, o_enc_valid, o_tx_type, o_tx_coded,
               o_am_insert, o_am_lane, o_deficit, o_deficit_ovf
    );

    // Upstream source / encoder side
    modport master (
        output i_enable, i_valid, i_tx_type, i_tx_coded,
        input  o_ready, o_enc_valid, o_tx_type, o_tx_coded,
               o_am_insert, o_am_lane, o_deficit, o_deficit_ovf
    );

endinterface
`default_nettype wire

// File: rtl/tx_am_scheduler_am_slot_counter.sv
`default_nettype none
// ============================================================================
//  Module      : am_slot_counter
//  Description : Slot counter over one AM period; flags the AM slots at the
//                head of each period and supplies their lane index.
//  Revision    : 1.0  initial release
// ============================================================================
module am_slot_counter
    import tx_am_scheduler_pkg::*;
#(
    parameter int N_LANES   = c_n_lanes_def,
    parameter int AM_PERIOD = c_am_period_def
) (
    input  wire logic                i_clock,
    input  wire logic                i_reset,
    input  wire logic                i_enable,
    output logic                     o_am_slot,
    output logic [c_lane_w-1:0]      o_am_lane
);

    localparam int CNT_W = (AM_PERIOD > 1) ? $clog2(AM_PERIOD) : 1;

    logic [CNT_W-1:0] r_slot_cnt;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_slot_cnt <= '0;
        end else if (i_enable) begin
            if (r_slot_cnt == CNT_W'(AM_PERIOD - 1)) begin
                r_slot_cnt <= '0;
            end else begin
                r_slot_cnt <= r_slot_cnt + 1'b1;
            end
        end
    end

    assign o_am_slot = (r_slot_cnt < CNT_W'(N_LANES));
    assign o_am_lane = c_lane_w'(r_slot_cnt);

endmodule
`default_nettype wire

// File: rtl/tx_am_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tx_am_scheduler
//  Description : Reserves AM slots every AM period, stalls upstream during them
//                and repays the lost bandwidth by deleting inter-frame idles.
//  Revision    : 1.0  initial release
// ============================================================================
module tx_am_scheduler
    import tx_am_scheduler_pkg::*;
#(
    parameter int NB_DATA_CODED = c_nb_data_coded_def,
    parameter int N_LANES       = c_n_lanes_def,
    parameter int AM_PERIOD     = c_am_period_def,
    parameter int MAX_DEFICIT   = c_max_deficit_def
) (
    input  wire logic          i_clock,
    input  wire logic          i_reset,
    tx_am_scheduler_if.slave   bus
);

    logic                      w_slot;
    logic                      w_am_slot;
    logic [c_lane_w-1:0]       w_am_lane;
    logic                      w_accept;
    logic                      w_delete;
    logic                      w_forward;
    logic                      w_deficit_sat;

    logic                      r_enc_valid;
    logic [c_type_w-1:0]       r_tx_type;
    logic [NB_DATA_CODED-1:0]  r_tx_coded;
    logic                      r_am_insert;
    logic [c_lane_w-1:0]       r_am_lane;
    logic [c_deficit_w-1:0]    r_deficit;
    logic                      r_deficit_ovf;
    logic                      r_in_frame;

    am_slot_counter #(
        .N_LANES   (N_LANES),
        .AM_PERIOD (AM_PERIOD)
    ) u_am_slot_counter (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_enable  (bus.i_enable),
        .o_am_slot (w_am_slot),
        .o_am_lane (w_am_lane)
    );

    assign w_slot        = bus.i_enable && !i_reset;
    assign bus.o_ready   = w_slot && !w_am_slot;
    assign w_accept      = bus.i_valid && bus.o_ready;
    // Only idles between frames may be dropped, and only while bandwidth is owed.
    assign w_delete      = w_accept && (bus.i_tx_type == TYPE_C) && !r_in_frame
                           && (r_deficit != '0);
    assign w_forward     = w_accept && !w_delete;
    assign w_deficit_sat = (r_deficit == c_deficit_w'(MAX_DEFICIT));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_enc_valid   <= 1'b0;
            r_tx_type     <= '0;
            r_tx_coded    <= '0;
            r_am_insert   <= 1'b0;
            r_am_lane     <= '0;
            r_deficit     <= '0;
            r_deficit_ovf <= 1'b0;
            r_in_frame    <= 1'b0;
        end else begin
            r_enc_valid <= w_forward;
            r_am_insert <= bus.i_enable && w_am_slot;

            if (bus.i_enable && w_am_slot) begin
                r_am_lane <= w_am_lane;
                if (w_deficit_sat) begin
                    r_deficit_ovf <= 1'b1;
                end else begin
                    r_deficit <= r_deficit + 1'b1;
                end
            end

            if (w_delete) begin
                r_deficit <= r_deficit - 1'b1;
            end

            if (w_forward) begin
                r_tx_type  <= bus.i_tx_type;
                r_tx_coded <= bus.i_tx_coded;
                r_in_frame <= next_in_frame(r_in_frame, bus.i_tx_type);
            end
        end
    end

    assign bus.o_enc_valid   = r_enc_valid;
    assign bus.o_tx_type     = r_tx_type;
    assign bus.o_tx_coded    = r_tx_coded;
    assign bus.o_am_insert   = r_am_insert;
    assign bus.o_am_lane     = r_am_lane;
    assign bus.o_deficit     = r_deficit;
    assign bus.o_deficit_ovf = r_deficit_ovf;

endmodule
`default_nettype wire
